gray_fifo_ptr: RTL

GRAY_FIFO_PTR -- requirements
Module: gray_fifo_ptr

---
 rtl/gray_fifo_ptr_pkg.sv | 12 +
 rtl/gray_decode_n.sv | 14 +
 rtl/gray_fifo_ptr.sv | 105 ++++++++++
 3 files changed

// File: rtl/gray_fifo_ptr_pkg.sv
// Shared constants and helpers for the Gray-coded FIFO pointer block.
package gray_fifo_ptr_pkg;

  localparam int DEFAULT_ADDR_WIDTH  = 5;
  localparam int DEFAULT_SYNC_STAGES = 2;

  // A pointer carries one extra wrap bit above the RAM address.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/gray_decode_n.sv
// Combinational Gray-to-binary decoder of arbitrary width.
module gray_decode_n #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign bin_o[gi] = ^gray_i[WIDTH-1:gi];
  end

endmodule

// File: rtl/gray_fifo_ptr.sv
// One side of an asynchronous FIFO: local binary/Gray pointer, synchroniser
// for the remote Gray pointer and the registered full (write role) or
// empty (read role) flag.
// Optional feature: define GRAY_FIFO_PTR_LEVEL_EN to add the level output.
// SYNC_STAGES must lie in 2..4.
module gray_fifo_ptr
  import gray_fifo_ptr_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int WRITE_SIDE  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic [ADDR_WIDTH:0]   remote_gray,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH:0]   ptr_gray,
  output logic                  flag
`ifdef GRAY_FIFO_PTR_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level
`endif
);

  localparam int PW = ptr_width(ADDR_WIDTH);

  // Full means the remote pointer is exactly one lap behind: in Gray code
  // that is the two top bits inverted, the rest equal. For PW=2 this mask
  // covers both bits.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  // Write side starts not-full, read side starts empty.
  localparam logic FLAG_RST = (WRITE_SIDE != 0) ? 1'b0 : 1'b1;

  logic [PW-1:0]                  ptr_bin_q, ptr_bin_d;
  logic [PW-1:0]                  ptr_gray_q, ptr_gray_d;
  logic                           flag_q, flag_d;
  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0]                  sync_gray;
  logic                           accept;

  assign sync_gray = sync_q[SYNC_STAGES-1];
  assign accept    = inc & ~flag_q;

  // Next pointer: advance by one on an accepted increment, wrapping naturally.
  always_comb begin
    ptr_bin_d = ptr_bin_q;
    if (accept) begin
      ptr_bin_d = ptr_bin_q + PW'(1);
    end
    ptr_gray_d = ptr_bin_d ^ (ptr_bin_d >> 1);
  end

  // Flag is evaluated against the pointer value it will sit beside next cycle.
  always_comb begin
    flag_d = 1'b0;
    if (WRITE_SIDE != 0) begin
      flag_d = (ptr_gray_d == (sync_gray ^ FULL_MASK));
    end else begin
      flag_d = (ptr_gray_d == sync_gray);
    end
  end

  // Local pointer and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_bin_q  <= '0;
      ptr_gray_q <= '0;
      flag_q     <= FLAG_RST;
    end else begin
      ptr_bin_q  <= ptr_bin_d;
      ptr_gray_q <= ptr_gray_d;
      flag_q     <= flag_d;
    end
  end

  // Remote pointer synchroniser; stage 0 samples the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], remote_gray};
    end
  end

  assign addr     = ptr_bin_q[ADDR_WIDTH-1:0];
  assign ptr_gray = ptr_gray_q;
  assign flag     = flag_q;

`ifdef GRAY_FIFO_PTR_LEVEL_EN
  logic [PW-1:0] sync_bin;

  gray_decode_n #(
    .WIDTH(PW)
  ) u_sync_decode (
    .gray_i(sync_gray),
    .bin_o (sync_bin)
  );

  // Occupancy as seen from this side, modulo the pointer range.
  assign level = (WRITE_SIDE != 0) ? (ptr_bin_q - sync_bin) : (sync_bin - ptr_bin_q);
`endif

endmodule
